// File: rtl/data_ram_resp_pkg.sv
// Shared types and constants for the data-RAM responder: bus widths, FSM encoding,
// the latched request record and the we_i encodings.
package data_ram_resp_pkg;

  localparam int WORD_W = 32;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte-address bits [1:0] are dropped at latch time; only the word address is kept.
  typedef struct packed {
    logic              we;
    sel_t              sel;
    logic [WORD_W-3:0] waddr;
    word_t             data;
  } mem_req_t;

endpackage

// File: rtl/sram_byte_array.sv
// Word-organised SRAM built from four byte-wide banks; per-lane write enable and a
// registered read port that holds its value when re is low.
module sram_byte_array
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              re,
  input  sel_t              we,
  input  logic [ADDR_W-1:0] idx,
  input  word_t             wdata,
  output word_t             rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Bank k carries data[8k+7:8k], so sel[3] maps to the most significant byte.
  for (genvar k = 0; k < SEL_W; k++) begin : g_bank
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we[k]) mem[idx] <= wdata[8*k +: 8];
      if (re)    rd_q     <= mem[idx];
    end

    assign rdata[8*k +: 8] = rd_q;
  end

endmodule

// File: rtl/data_ram_resp.sv
// Memory-side responder for the core's data-RAM port: latches one request, waits
// WAIT_CYCLES, performs the array access, and stalls the pipeline until DONE.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  ce_i,
  input  logic  we_i,
  input  word_t addr_i,
  input  sel_t  sel_i,
  input  word_t data_i,
  output word_t data_o,
  output logic  stallreq_o,
  output logic  err_o
);

  state_e   state;
  cnt_t     cnt;
  mem_req_t req_q;
  logic     rd_zero;
  word_t    rdata;

  logic              access;
  logic              oor;
  logic [ADDR_W-1:0] idx;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];

  assign access = (state == BUSY) && (cnt == '0);
  assign oor    = |req_q.waddr[WORD_W-3:ADDR_W];
  assign idx    = req_q.waddr[ADDR_W-1:0];

  // Combinational on ce_i so the core already holds MEM in the request cycle.
  assign stallreq_o = ((state == IDLE) && ce_i) || (state == BUSY);

  sram_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .re    (access && (req_q.we == READ_ENABLE) && !oor),
    .we    ((access && (req_q.we == WRITE_ENABLE) && !oor) ? req_q.sel : '0),
    .idx   (idx),
    .wdata (req_q.data),
    .rdata (rdata)
  );

  // The array read register is not reset; rd_zero forces data_o to 0 after reset
  // and after an out-of-range read, until the next in-range read lands.
  assign data_o = rd_zero ? '0 : rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      err_o   <= 1'b0;
      rd_zero <= 1'b1;
      req_q   <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ce_i) begin
            req_q <= '{we: we_i, sel: sel_i, waddr: addr_i[WORD_W-1:2], data: data_i};
            cnt   <= CNT_W'(WAIT_CYCLES);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            err_o <= oor;
            if (req_q.we == READ_ENABLE) rd_zero <= oor;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp: one instance with WAIT_CYCLES=1, one with 0.
module tb_data_ram_resp;
  logic        clk = 1'b0;
  logic        rst;
  logic        ce1, ce0;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data1, data0;
  logic        stall1, stall0, err1, err0;

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 1;

  logic [31:0] d_o;
  logic        st_o, er_o;
  assign d_o  = (cur == 1) ? data1  : data0;
  assign st_o = (cur == 1) ? stall1 : stall0;
  assign er_o = (cur == 1) ? err1   : err0;

  always #5 clk = ~clk;

  data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .ce_i(ce1), .we_i(we_i), .addr_i(addr_i), .sel_i(sel_i),
    .data_i(data_i), .data_o(data1), .stallreq_o(stall1), .err_o(err1));

  data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we_i), .addr_i(addr_i), .sel_i(sel_i),
    .data_i(data_i), .data_o(data0), .stallreq_o(stall0), .err_o(err0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full access on instance wt; ce stays high through DONE like the core would.
  task automatic access(input int wt, input logic we, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e, input string tag);
    cur = wt;
    if (wt == 1) ce1 = 1'b1; else ce0 = 1'b1;
    we_i = we; addr_i = a; sel_i = s; data_i = d;
    for (int i = 0; i < wt + 2; i++) begin
      @(negedge clk);
      check({tag, "_stall_hi"}, {31'd0, st_o}, 32'd1);
      check({tag, "_err_lo"},   {31'd0, er_o}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, "_stall_done"}, {31'd0, st_o}, 32'd0);
    check({tag, "_err_done"},   {31'd0, er_o}, {31'd0, exp_e});
    if (we == 1'b0) check({tag, "_data"}, d_o, exp_d);
    @(posedge clk); #1;
    ce1 = 1'b0; ce0 = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ce1 = 1'b0; ce0 = 1'b0; we_i = 1'b0;
    addr_i = '0; sel_i = '0; data_i = '0;
    @(negedge clk);
    check("rst_data1", data1, 32'd0);
    check("rst_stall1", {31'd0, stall1}, 32'd0);
    check("rst_err1", {31'd0, err1}, 32'd0);
    check("rst_data0", data0, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: full-word write, then read back
    access(1, 1'b1, 32'h40, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, "t1_wr");
    access(1, 1'b0, 32'h40, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, "t1_rd");

    // 2: byte-lane write, empty-sel write
    access(1, 1'b1, 32'h40, 4'b0010, 32'h0000AB00, 32'h0, 1'b0, "t2_wr");
    access(1, 1'b0, 32'h40, 4'b1111, 32'h0, 32'hDEADABEF, 1'b0, "t2_rd");
    access(1, 1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0, "t2_wr0");
    access(1, 1'b0, 32'h40, 4'b1111, 32'h0, 32'hDEADABEF, 1'b0, "t2_rd0");

    // 3: out-of-range write must not alias onto index 0
    access(1, 1'b1, 32'h0, 4'b1111, 32'h0A0B0C0D, 32'h0, 1'b0, "t3_wr0");
    access(1, 1'b1, 32'h1000, 4'b1111, 32'h12345678, 32'h0, 1'b1, "t3_wr_oor");
    access(1, 1'b0, 32'h0, 4'b1111, 32'h0, 32'h0A0B0C0D, 1'b0, "t3_rd0");
    access(1, 1'b0, 32'h1000, 4'b1111, 32'h0, 32'h0, 1'b1, "t3_rd_oor");
    @(negedge clk);
    check("t3_err_pulse_end", {31'd0, err1}, 32'd0);
    @(posedge clk); #1;

    // 4: zero wait states, back-to-back reads
    access(0, 1'b1, 32'h40, 4'b1111, 32'h01020304, 32'h0, 1'b0, "t4_wr40");
    access(0, 1'b1, 32'h44, 4'b1111, 32'hA5A5A5A5, 32'h0, 1'b0, "t4_wr44");
    access(0, 1'b0, 32'h40, 4'b1111, 32'h0, 32'h01020304, 1'b0, "t4_rd40");
    access(0, 1'b0, 32'h44, 4'b1111, 32'h0, 32'hA5A5A5A5, 1'b0, "t4_rd44");
    @(negedge clk);
    check("t4_idle_stall", {31'd0, stall0}, 32'd0);
    @(posedge clk); #1;

    // 5: reset in first BUSY cycle of a write abandons it
    access(1, 1'b1, 32'h80, 4'b1111, 32'h11111111, 32'h0, 1'b0, "t5_wr");
    access(1, 1'b0, 32'h80, 4'b1111, 32'h0, 32'h11111111, 1'b0, "t5_rd");
    cur = 1;
    ce1 = 1'b1; we_i = 1'b1; addr_i = 32'h80; sel_i = 4'b1111; data_i = 32'h22222222;
    @(posedge clk); #1;
    rst = 1'b0; ce1 = 1'b0;
    #1;
    check("t5_rst_data", data1, 32'd0);
    check("t5_rst_stall", {31'd0, stall1}, 32'd0);
    check("t5_rst_err", {31'd0, err1}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    access(1, 1'b0, 32'h80, 4'b1111, 32'h0, 32'h11111111, 1'b0, "t5_rd_after");

    // 6: inputs changing during BUSY are ignored
    access(1, 1'b1, 32'hC4, 4'b1111, 32'h55555555, 32'h0, 1'b0, "t6_wrC4");
    cur = 1;
    ce1 = 1'b1; we_i = 1'b1; addr_i = 32'hC0; sel_i = 4'b1111; data_i = 32'h12345678;
    @(posedge clk); #1;
    addr_i = 32'hC4; data_i = 32'h0BADBEEF; we_i = 1'b0; sel_i = 4'b0000;
    @(negedge clk);
    check("t6_busy_stall", {31'd0, stall1}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_done_stall", {31'd0, stall1}, 32'd0);
    check("t6_done_err", {31'd0, err1}, 32'd0);
    ce1 = 1'b0;
    @(posedge clk); #1;
    access(1, 1'b0, 32'hC0, 4'b1111, 32'h0, 32'h12345678, 1'b0, "t6_rdC0");
    access(1, 1'b0, 32'hC4, 4'b1111, 32'h0, 32'h55555555, 1'b0, "t6_rdC4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
